// File: rtl/wash_session_ctrl_if.sv
//------------------------------------------------------------------------------
// Module  : wash_session_ctrl_if
// Brief   : Control/status bundle between wash_session_ctrl and its environment.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface wash_session_ctrl_if;
    logic        CoinPulse;
    logic [3:0]  ModeSel;
    logic        StartBtn;
    logic        PauseBtn;
    logic [11:0] PresentTime;
    logic [3:0]  CounterInput;
    logic        CounterEnable;
    logic        CounterClr;
    logic [3:0]  Credits;
    logic        Busy;
    logic        Done;
    logic        Fault;
    logic [2:0]  State;

    modport slave (
        input  CoinPulse, ModeSel, StartBtn, PauseBtn, PresentTime,
        output CounterInput, CounterEnable, CounterClr, Credits, Busy, Done, Fault, State
    );

    modport master (
        output CoinPulse, ModeSel, StartBtn, PauseBtn, PresentTime,
        input  CounterInput, CounterEnable, CounterClr, Credits, Busy, Done, Fault, State
    );
endinterface

`default_nettype wire

// File: rtl/wash_session_ctrl.sv
//------------------------------------------------------------------------------
// Module  : wash_session_ctrl
// Brief   : Coin-operated wash session controller driving a BCD countdown timer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wash_session_ctrl #(
    parameter int COIN_PRICE = 2,
    parameter int DONE_HOLD  = 8,
    parameter int CREDIT_MAX = 15
) (
    input  wire logic          Clk,
    input  wire logic          Reset,
    wash_session_ctrl_if.slave bus
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_READY = 3'd1;
    localparam logic [2:0] c_LOAD  = 3'd2;
    localparam logic [2:0] c_RUN   = 3'd3;
    localparam logic [2:0] c_PAUSE = 3'd4;
    localparam logic [2:0] c_DONE  = 3'd5;
    localparam logic [2:0] c_FAULT = 3'd6;

    localparam int                    c_HOLD_W    = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;
    localparam logic [c_HOLD_W-1:0]   c_HOLD_LAST = c_HOLD_W'(DONE_HOLD - 1);
    localparam logic [4:0]            c_PRICE5    = 5'(COIN_PRICE);
    localparam logic [4:0]            c_CMAX5     = 5'(CREDIT_MAX);

    logic [2:0]          r_state;
    logic [3:0]          r_credits;
    logic [3:0]          r_counterInput;
    logic                r_seenNz;
    logic [c_HOLD_W-1:0] r_holdCnt;

    logic [2:0] w_stateNext;
    logic [4:0] w_creditSum;
    logic [3:0] w_creditNext;
    logic       w_timeBad;
    logic       w_timeZero;
    logic       w_creditOk;
    logic       w_modeOk;

    // A digit above 9 means the timer word is corrupt.
    assign w_timeBad  = (bus.PresentTime[11:8] > 4'd9) ||
                        (bus.PresentTime[7:4]  > 4'd9) ||
                        (bus.PresentTime[3:0]  > 4'd9);
    assign w_timeZero = (bus.PresentTime == 12'h000);
    assign w_creditOk = ({1'b0, r_credits} >= c_PRICE5);
    assign w_modeOk   = (bus.ModeSel == 4'd1) || (bus.ModeSel == 4'd2);

    // Credits can never fall below the price while in LOAD, so the subtraction cannot wrap.
    always_comb begin
        w_creditSum = {1'b0, r_credits};
        if (bus.CoinPulse && (r_state != c_FAULT)) begin
            w_creditSum = w_creditSum + 5'd1;
        end
        if (r_state == c_LOAD) begin
            w_creditSum = w_creditSum - c_PRICE5;
        end
        w_creditNext = (w_creditSum > c_CMAX5) ? c_CMAX5[3:0] : w_creditSum[3:0];
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_creditOk) w_stateNext = c_READY;
            end
            c_READY: begin
                if (bus.StartBtn && w_modeOk) w_stateNext = c_LOAD;
            end
            c_LOAD: begin
                w_stateNext = c_RUN;
            end
            c_RUN: begin
                if (w_timeBad)                   w_stateNext = c_FAULT;
                else if (w_timeZero && r_seenNz) w_stateNext = c_DONE;
                else if (bus.PauseBtn)           w_stateNext = c_PAUSE;
            end
            c_PAUSE: begin
                if (w_timeBad)         w_stateNext = c_FAULT;
                else if (bus.PauseBtn) w_stateNext = c_RUN;
            end
            c_DONE: begin
                if (r_holdCnt == c_HOLD_LAST) w_stateNext = w_creditOk ? c_READY : c_IDLE;
            end
            c_FAULT: begin
                w_stateNext = c_FAULT;
            end
            default: begin
                w_stateNext = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state        <= c_IDLE;
            r_credits      <= 4'd0;
            r_counterInput <= 4'd9;
            r_seenNz       <= 1'b0;
            r_holdCnt      <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_credits <= w_creditNext;

            if ((r_state == c_READY) && bus.StartBtn && w_modeOk) begin
                r_counterInput <= (bus.ModeSel == 4'd1) ? 4'd1 : 4'd9;
            end

            // Zero only counts as expiry once the timer has shown a non-zero value.
            if (r_state == c_LOAD) begin
                r_seenNz <= 1'b0;
            end else if ((r_state == c_RUN) && !w_timeZero) begin
                r_seenNz <= 1'b1;
            end

            if (r_state == c_DONE) r_holdCnt <= r_holdCnt + 1'b1;
            else                   r_holdCnt <= '0;
        end
    end

    assign bus.State         = r_state;
    assign bus.Credits       = r_credits;
    assign bus.CounterInput  = r_counterInput;
    assign bus.CounterClr    = (r_state == c_LOAD);
    assign bus.CounterEnable = (r_state == c_RUN);
    assign bus.Busy          = (r_state == c_LOAD) || (r_state == c_RUN) || (r_state == c_PAUSE);
    assign bus.Done          = (r_state == c_DONE);
    assign bus.Fault         = (r_state == c_FAULT);

endmodule

`default_nettype wire
